// File: rtl/vxe_txnid_resp_router.sv
// vxe_txnid_resp_router
// Routes returning memory responses to CU, VPU0 or VPU1 by decoding the
// client field of the transaction Id. Each client owns a small FIFO so a
// stalled client only back-pressures responses addressed to itself.
// Responses carrying the invalid client Id 3 are always accepted and dropped;
// they raise a sticky error flag and bump a saturating drop counter.

module vxe_txnid_resp_router #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_rss_vld,
    output logic                  o_rss_rdy,
    input  logic [5:0]            i_rss_txnid,
    input  logic [DATA_WIDTH-1:0] i_rss_data,

    output logic                  o_cu_vld,
    input  logic                  i_cu_rdy,
    output logic [2:0]            o_cu_thread,
    output logic                  o_cu_arg,
    output logic [DATA_WIDTH-1:0] o_cu_data,

    output logic                  o_vpu0_vld,
    input  logic                  i_vpu0_rdy,
    output logic [2:0]            o_vpu0_thread,
    output logic                  o_vpu0_arg,
    output logic [DATA_WIDTH-1:0] o_vpu0_data,

    output logic                  o_vpu1_vld,
    input  logic                  i_vpu1_rdy,
    output logic [2:0]            o_vpu1_thread,
    output logic                  o_vpu1_arg,
    output logic [DATA_WIDTH-1:0] o_vpu1_data,

    output logic                  o_err_inval,
    input  logic                  i_err_clr,
    output logic [7:0]            o_drop_cnt
);

    localparam int NUM_CLIENTS = 3;
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = PTR_W + 1;
    localparam int ENTRY_W     = 3 + 1 + DATA_WIDTH;

    localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(FIFO_DEPTH);

    // Decoded fields of the incoming transaction Id
    logic [1:0]         client_id;
    logic [ENTRY_W-1:0] in_entry;

    // Per-client FIFO storage and bookkeeping
    logic [ENTRY_W-1:0] fifo_mem [NUM_CLIENTS][FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr   [NUM_CLIENTS];
    logic [PTR_W-1:0]   rd_ptr   [NUM_CLIENTS];
    logic [CNT_W-1:0]   level    [NUM_CLIENTS];
    logic [ENTRY_W-1:0] last_pop [NUM_CLIENTS];
    logic [ENTRY_W-1:0] head     [NUM_CLIENTS];

    logic [NUM_CLIENTS-1:0] full;
    logic [NUM_CLIENTS-1:0] empty;
    logic [NUM_CLIENTS-1:0] push;
    logic [NUM_CLIENTS-1:0] pop;
    logic [NUM_CLIENTS-1:0] client_rdy;

    logic accept;
    logic drop;

    assign client_id  = i_rss_txnid[5:4];
    assign in_entry   = {i_rss_txnid[3:1], i_rss_txnid[0], i_rss_data};
    assign client_rdy = {i_vpu1_rdy, i_vpu0_rdy, i_cu_rdy};

    // Occupancy flags and head selection; an empty FIFO keeps showing the last popped entry
    always_comb begin
        full  = '0;
        empty = '0;
        for (int c = 0; c < NUM_CLIENTS; c++) begin
            full[c]  = (level[c] == FULL_LEVEL);
            empty[c] = (level[c] == '0);
            head[c]  = empty[c] ? last_pop[c] : fifo_mem[c][rd_ptr[c]];
        end
    end

    // Ready depends only on the addressed FIFO; invalid Ids are always swallowed
    always_comb begin
        o_rss_rdy = 1'b1;
        case (client_id)
            2'd0:    o_rss_rdy = ~full[0];
            2'd1:    o_rss_rdy = ~full[1];
            2'd2:    o_rss_rdy = ~full[2];
            default: o_rss_rdy = 1'b1;
        endcase
    end

    assign accept = i_rss_vld & o_rss_rdy;
    assign drop   = accept & (client_id == 2'd3);

    // Steer an accepted response to the push of its client and form per-client pops
    always_comb begin
        push = '0;
        pop  = '0;
        for (int c = 0; c < NUM_CLIENTS; c++) begin
            push[c] = accept & (client_id == 2'(c));
            pop[c]  = ~empty[c] & client_rdy[c];
        end
    end

    // Write accepted responses at each FIFO tail; contents need no reset because level gates visibility
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CLIENTS; c++) begin
            if (push[c]) begin
                fifo_mem[c][wr_ptr[c]] <= in_entry;
            end
        end
    end

    // Pointer, occupancy and last-popped tracking for every client FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CLIENTS; c++) begin
                wr_ptr[c]   <= '0;
                rd_ptr[c]   <= '0;
                level[c]    <= '0;
                last_pop[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CLIENTS; c++) begin
                if (push[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + 1'b1;
                end
                if (pop[c]) begin
                    rd_ptr[c]   <= rd_ptr[c] + 1'b1;
                    last_pop[c] <= fifo_mem[c][rd_ptr[c]];
                end
                if (push[c] && !pop[c]) begin
                    level[c] <= level[c] + 1'b1;
                end else if (pop[c] && !push[c]) begin
                    level[c] <= level[c] - 1'b1;
                end
            end
        end
    end

    // Sticky invalid-Id flag and saturating drop counter; a clear beats a simultaneous drop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_err_inval <= 1'b0;
            o_drop_cnt  <= '0;
        end else if (i_err_clr) begin
            o_err_inval <= 1'b0;
            o_drop_cnt  <= '0;
        end else if (drop) begin
            o_err_inval <= 1'b1;
            if (o_drop_cnt != 8'hFF) begin
                o_drop_cnt <= o_drop_cnt + 8'd1;
            end
        end
    end

    assign o_cu_vld      = ~empty[0];
    assign o_cu_thread   = head[0][ENTRY_W-1 -: 3];
    assign o_cu_arg      = head[0][DATA_WIDTH];
    assign o_cu_data     = head[0][DATA_WIDTH-1:0];

    assign o_vpu0_vld    = ~empty[1];
    assign o_vpu0_thread = head[1][ENTRY_W-1 -: 3];
    assign o_vpu0_arg    = head[1][DATA_WIDTH];
    assign o_vpu0_data   = head[1][DATA_WIDTH-1:0];

    assign o_vpu1_vld    = ~empty[2];
    assign o_vpu1_thread = head[2][ENTRY_W-1 -: 3];
    assign o_vpu1_arg    = head[2][DATA_WIDTH];
    assign o_vpu1_data   = head[2][DATA_WIDTH-1:0];

endmodule

// File: doc/vxe_txnid_resp_router.md
Name: vxe_txnid_resp_router

Overview:
- Decodes the 6-bit transaction Id on returning memory responses and routes each response to its originating client: CU, VPU0 or VPU1.
- Txn Id layout is fixed: [5:4] client Id (0=CU, 1=VPU0, 2=VPU1, 3=invalid), [3:1] thread Id, [0] argument (0=Rs, 1=Rt).
- Each client has its own small FIFO, so a stalled client does not block responses for the other clients unless that client's own FIFO is full.
- The block sits between the memory interface response channel and the CU/VPU response inputs.

Parameters:
- DATA_WIDTH, 64, response data width.
- FIFO_DEPTH, 2, entries per client FIFO. Must be a power of two and at least 2.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- i_rss_vld  input  1  response valid
- o_rss_rdy  output  1  response accepted this cycle when i_rss_vld is also high
- i_rss_txnid  input  6  transaction Id of the response
- i_rss_data  input  DATA_WIDTH  response data
- o_cu_vld  output  1  CU response valid
- i_cu_rdy  input  1  CU ready
- o_cu_thread  output  3  thread Id of the CU response
- o_cu_arg  output  1  argument (Rs/Rt) of the CU response
- o_cu_data  output  DATA_WIDTH  CU response data
- o_vpu0_vld / i_vpu0_rdy / o_vpu0_thread / o_vpu0_arg / o_vpu0_data  as the CU group, for VPU0
- o_vpu1_vld / i_vpu1_rdy / o_vpu1_thread / o_vpu1_arg / o_vpu1_data  as the CU group, for VPU1
- o_err_inval  output  1  sticky flag: a response with client Id 3 was received
- i_err_clr  input  1  clears o_err_inval and o_drop_cnt
- o_drop_cnt  output  8  saturating count of dropped responses

Behaviour:
- Reset (async assert, released synchronously to clk):
  - all FIFOs empty and pointers zero;
  - all o_*_vld = 0, o_*_thread = 0, o_*_arg = 0, o_*_data = 0;
  - o_err_inval = 0, o_drop_cnt = 0.
- Reset asserted mid-operation discards all buffered entries immediately; no partial output state survives.
- Decode is combinational from i_rss_txnid. Each FIFO entry stores {thread, arg, data}.
- o_rss_rdy is combinational:
  - client Id 0/1/2: rdy = target FIFO not full;
  - client Id 3: rdy = 1.
  - rdy depends only on txnid and FIFO occupancy, never on i_*_rdy. There is no pass-through, so a full FIFO gives rdy = 0 even when the client pops in the same cycle.
- Accept = i_rss_vld & o_rss_rdy. An accepted valid client response is written at the FIFO tail on the clock edge.
- Minimum latency is 1 cycle: a response accepted at edge N appears with o_x_vld = 1 after edge N.
- Output side:
  - o_x_vld = FIFO not empty; thread/arg/data present the head entry.
  - Pop = o_x_vld & i_x_rdy.
  - When empty, thread/arg/data hold the last popped values (zero after reset).
- Push and pop may happen in the same cycle; occupancy is then unchanged. Pointers wrap modulo FIFO_DEPTH. Occupancy counter is clog2(FIFO_DEPTH)+1 bits wide.
- Per-client order is preserved. There is no ordering across clients.
- Invalid client Id (3), when accepted:
  - the response is dropped;
  - o_err_inval is set on the next edge;
  - o_drop_cnt increments and saturates at 255.
- i_err_clr:
  - clears o_err_inval and o_drop_cnt on the next edge;
  - if a drop happens in the same cycle, the clear wins, and the result is flag = 0, cnt = 0.
- Once asserted, o_*_vld stays high with stable thread/arg/data until popped.

Test Plan:
- After reset, drive txnid 6'b01_101_1 (VPU0, thread 5, Rt), data 64'hDEAD_BEEF with i_vpu0_rdy = 1 → o_rss_rdy = 1; one cycle later o_vpu0_vld = 1, thread = 5, arg = 1, data = DEAD_BEEF; o_cu_vld = o_vpu1_vld = 0.
- Hold i_cu_rdy = 0 and send 3 CU responses (data 1, 2, 3) → first two accepted, o_rss_rdy = 0 on the third. Raise i_cu_rdy → pops return 1 then 2. Third accepted only on the cycle after the first pop. Order is 1, 2, 3.
- CU FIFO full, then send a VPU1 response (txnid 6'b10_000_0) → accepted immediately; o_vpu1_vld = 1 next cycle while CU remains stalled.
- Send txnid 6'b11_010_0 three times → o_rss_rdy = 1 each time, no client valid, o_err_inval = 1, o_drop_cnt = 3. Pulse i_err_clr together with a fourth drop → flag = 0, cnt = 0.
- Send 260 invalid responses → o_drop_cnt saturates at 255.
- Assert rst with 2 entries in the VPU0 FIFO and o_vpu0_vld = 1 → o_vpu0_vld = 0 immediately (asynchronous); after release the FIFO is empty and outputs are zero.
